// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: issues FIFO reads, absorbs the one-cycle read latency and
// presents words on a framed valid/ready stream through a two-slot skid buffer.
module fifo_rd_stream_adapter #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk_r,
    input  logic             reset_r,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] words_out,
    output logic [1:0]       buf_lvl
);

    localparam int FCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BURST_LEN - 1);

    logic              head_reg, head_next;
    logic              tail_reg, tail_next;
    logic [1:0]        lvl_reg, lvl_next;
    logic              inflight_reg;
    logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
    logic [CNT_W-1:0]  words_reg;
    logic              pop;
    logic              push;
    logic              rd;
    logic [2:0]        occ;

    assign pop  = m_valid & m_ready;
    assign push = inflight_reg & ~flush;

    // Occupancy after this edge counts the word still coming back from the FIFO,
    // so a read is only issued when a slot is guaranteed for it.
    assign occ = {1'b0, lvl_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign rd  = reset_r & ~fifo_empty & ~flush & (occ < 3'd2);

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        lvl_next  = lvl_reg;
        fcnt_next = fcnt_reg;
        if (flush) begin
            head_next = 1'b0;
            tail_next = 1'b0;
            lvl_next  = 2'd0;
            fcnt_next = '0;
        end else begin
            if (push) begin
                tail_next = ~tail_reg;
            end
            if (pop) begin
                head_next = ~head_reg;
                fcnt_next = (fcnt_reg == FCNT_LAST) ? '0 : fcnt_reg + 1'b1;
            end
            lvl_next = lvl_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_r or negedge reset_r) begin
        if (!reset_r) begin
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
            lvl_reg      <= 2'd0;
            fcnt_reg     <= '0;
            inflight_reg <= 1'b0;
            words_reg    <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            lvl_reg      <= lvl_next;
            fcnt_reg     <= fcnt_next;
            inflight_reg <= rd;
            if (pop) begin
                words_reg <= words_reg + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic [WIDTH-1:0] data_reg;
        always_ff @(posedge clk_r or negedge reset_r) begin
            if (!reset_r) begin
                data_reg <= '0;
            end else if (push && (tail_reg == 1'(gi))) begin
                data_reg <= fifo_rdata;
            end
        end
    end

    assign m_data     = head_reg ? g_slot[1].data_reg : g_slot[0].data_reg;
    assign m_valid    = (lvl_reg != 2'd0);
    assign m_last     = m_valid & (fcnt_reg == FCNT_LAST);
    assign fifo_rd_en = rd;
    assign words_out  = words_reg;
    assign buf_lvl    = lvl_reg;

    a_no_overflow: assert property (@(posedge clk_r) disable iff (!reset_r)
        !(push && (lvl_reg == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: a behavioural FIFO with one-cycle
// read latency feeds two instances (16-bit and 4-bit word counters).
module tb_fifo_rd_stream_adapter;
    localparam int W = 32;

    logic          clk_r = 1'b0;
    logic          reset_r = 1'b0;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          empty_force = 1'b0;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata = '0;
    logic          fifo_rd_en, m_valid, m_last;
    logic [W-1:0]  m_data;
    logic [15:0]   words_out;
    logic [1:0]    buf_lvl;
    logic          rd_en_w, m_valid_w, m_last_w;
    logic [W-1:0]  m_data_w;
    logic [3:0]    words_w;
    logic [1:0]    lvl_w;

    logic [W-1:0]  mem [0:255];
    int wr_idx = 0;
    int rd_idx = 0;
    int exp_idx = 0;
    int exp_fcnt = 0;
    int n_last = 0;
    int n_assert = 0;
    int n_fail = 0;

    fifo_rd_stream_adapter #(.WIDTH(W), .BURST_LEN(16), .CNT_W(16)) dut (
        .clk_r(clk_r), .reset_r(reset_r), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .words_out(words_out), .buf_lvl(buf_lvl)
    );

    fifo_rd_stream_adapter #(.WIDTH(W), .BURST_LEN(16), .CNT_W(4)) dut_w (
        .clk_r(clk_r), .reset_r(reset_r), .flush(flush), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(rd_en_w), .m_data(m_data_w),
        .m_valid(m_valid_w), .m_ready(m_ready), .m_last(m_last_w),
        .words_out(words_w), .buf_lvl(lvl_w)
    );

    always #5 clk_r = ~clk_r;

    assign fifo_empty = (rd_idx == wr_idx) || empty_force;

    always @(posedge clk_r) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_idx];
            rd_idx     <= rd_idx + 1;
        end
    end

    typedef struct {
        logic       rdy;
        logic       fl;
        logic       e_rd;
        logic       e_valid;
        logic [1:0] e_lvl;
        int         e_word;
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_idx] = 32'hA500_0000 + 32'(wr_idx);
            wr_idx++;
        end
    endtask

    // Samples 1 time unit after inputs change; scores any pop happening at the next edge.
    task automatic settle();
        #1;
        if (fifo_empty) chk("no_rd_when_empty", {63'd0, fifo_rd_en}, 64'd0);
        if (m_valid && m_ready) begin
            chk("pop_data", {32'd0, m_data}, {32'd0, mem[exp_idx]});
            chk("pop_last", {63'd0, m_last}, {63'd0, exp_fcnt == 15});
            $display("pop word %0d data=%h last=%b words_out=%0d", exp_idx, m_data, m_last, words_out);
            if (m_last) n_last++;
            exp_idx++;
            exp_fcnt = (exp_fcnt + 1) % 16;
        end
        if (flush) begin
            exp_fcnt = 0;
            exp_idx  = rd_idx;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_reads;
        int base;
        int lb;

        // startup latency, then 10 cycles of backpressure, release, short stall
        vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, -1};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, -1};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 0};
        for (int i = 3; i < 10; i++) vec[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 0};
        vec[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 0};
        vec[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1};
        vec[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2};
        vec[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3};
        vec[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3};
        vec[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 3};
        vec[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4};

        // reset with a non-empty FIFO
        load(40);
        @(negedge clk_r);
        #1;
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_words", {48'd0, words_out}, 64'd0);
        chk("rst_lvl", {62'd0, buf_lvl}, 64'd0);
        chk("rst_data", {32'd0, m_data}, 64'd0);
        @(negedge clk_r);
        reset_r = 1'b1;

        bp_reads = 0;
        for (int i = 0; i < 17; i++) begin
            m_ready = vec[i].rdy;
            flush   = vec[i].fl;
            settle();
            chk($sformatf("vec%0d_rd", i), {63'd0, fifo_rd_en}, {63'd0, vec[i].e_rd});
            chk($sformatf("vec%0d_valid", i), {63'd0, m_valid}, {63'd0, vec[i].e_valid});
            chk($sformatf("vec%0d_lvl", i), {62'd0, buf_lvl}, {62'd0, vec[i].e_lvl});
            if (vec[i].e_word >= 0)
                chk($sformatf("vec%0d_data", i), {32'd0, m_data}, {32'd0, mem[vec[i].e_word]});
            if (i < 10 && fifo_rd_en) bp_reads++;
            @(negedge clk_r);
        end
        chk("bp_reads", 64'(bp_reads), 64'd2);

        // continuous stream of the remaining words
        m_ready = 1'b1;
        for (int c = 0; c < 100 && exp_idx < 40; c++) begin
            settle();
            chk("stream_valid", {63'd0, m_valid}, 64'd1);
            @(negedge clk_r);
        end
        chk("stream_done", 64'(exp_idx), 64'd40);
        settle();
        chk("words_out_40", {48'd0, words_out}, 64'd40);
        chk("words_w_40", {60'd0, words_w}, 64'd8);
        chk("drained_lvl", {62'd0, buf_lvl}, 64'd0);
        chk("last_count", 64'(n_last), 64'd2);
        @(negedge clk_r);

        // alternating ready with the FIFO flickering empty
        load(30);
        for (int c = 0; c < 120; c++) begin
            m_ready     = (c % 2 == 0);
            empty_force = ((c / 3) % 2 == 1);
            settle();
            @(negedge clk_r);
        end
        m_ready     = 1'b1;
        empty_force = 1'b0;
        for (int c = 0; c < 200 && exp_idx < 70; c++) begin
            settle();
            @(negedge clk_r);
        end
        chk("alt_done", 64'(exp_idx), 64'd70);
        settle();
        chk("alt_words", {48'd0, words_out}, 64'd70);
        chk("alt_words_w", {60'd0, words_w}, 64'd6);
        chk("alt_lvl", {62'd0, buf_lvl}, 64'd0);
        @(negedge clk_r);

        // flush mid-stream after 5 words
        m_ready = 1'b0;
        reset_r = 1'b0;
        @(negedge clk_r);
        exp_idx  = rd_idx;
        exp_fcnt = 0;
        base     = exp_idx;
        load(30);
        reset_r = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 30 && exp_idx < base + 5; c++) begin
            settle();
            @(negedge clk_r);
        end
        chk("pre_flush_pops", 64'(exp_idx - base), 64'd5);
        m_ready = 1'b0;
        flush   = 1'b1;
        settle();
        chk("flush_rd", {63'd0, fifo_rd_en}, 64'd0);
        @(negedge clk_r);
        flush = 1'b0;
        settle();
        chk("flush_valid", {63'd0, m_valid}, 64'd0);
        chk("flush_lvl", {62'd0, buf_lvl}, 64'd0);
        chk("flush_words", {48'd0, words_out}, 64'd5);
        @(negedge clk_r);
        base    = exp_idx;
        lb      = n_last;
        m_ready = 1'b1;
        for (int c = 0; c < 60 && exp_idx < base + 16; c++) begin
            settle();
            @(negedge clk_r);
        end
        m_ready = 1'b0;
        chk("flush_frame_done", 64'(exp_idx - base), 64'd16);
        chk("flush_one_last", 64'(n_last - lb), 64'd1);
        settle();
        chk("flush_words_21", {48'd0, words_out}, 64'd21);
        @(negedge clk_r);

        // counter wrap, then asynchronous reset mid-burst
        reset_r = 1'b0;
        @(negedge clk_r);
        exp_idx  = rd_idx;
        exp_fcnt = 0;
        base     = exp_idx;
        load(40);
        reset_r = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 60 && exp_idx < base + 20; c++) begin
            settle();
            @(negedge clk_r);
        end
        m_ready = 1'b0;
        settle();
        chk("wrap_words", {48'd0, words_out}, 64'd20);
        chk("wrap_words_w", {60'd0, words_w}, 64'd4);
        @(negedge clk_r);
        m_ready = 1'b1;
        settle();
        @(negedge clk_r);
        settle();
        @(negedge clk_r);
        #1;
        chk("mid_burst_valid", {63'd0, m_valid}, 64'd1);
        #1;
        reset_r = 1'b0;
        #1;
        chk("arst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("arst_valid", {63'd0, m_valid}, 64'd0);
        chk("arst_last", {63'd0, m_last}, 64'd0);
        chk("arst_data", {32'd0, m_data}, 64'd0);
        chk("arst_words", {48'd0, words_out}, 64'd0);
        chk("arst_lvl", {62'd0, buf_lvl}, 64'd0);
        chk("arst_w_outs", {57'd0, rd_en_w, m_valid_w, m_last_w, words_w}, 64'd0);
        chk("arst_w_data", {30'd0, lvl_w, m_data_w}, 64'd0);
        @(negedge clk_r);
        exp_idx  = rd_idx;
        exp_fcnt = 0;
        base     = exp_idx;
        reset_r  = 1'b1;
        for (int c = 0; c < 30 && exp_idx < base + 5; c++) begin
            settle();
            @(negedge clk_r);
        end
        m_ready = 1'b0;
        chk("resume_pops", 64'(exp_idx - base), 64'd5);
        settle();
        chk("resume_words", {48'd0, words_out}, 64'd5);
        chk("resume_words_w", {60'd0, words_w}, 64'd5);
        @(negedge clk_r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
